// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter plus serial framer for one shared UART transmit path.
// Frame: start, 8 data bits LSB-first, even parity, stop; each bit lasts SAMPLES_PER_BIT strobes.
module uart_tx_scheduler #(
  parameter int          SAMPLES_PER_BIT = 16,
  parameter logic [2:0]  RESET_BAUD      = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ENABLE,
  input  logic [2:0] cfg_baud_select,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int             CW       = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0]  LAST_SMP = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity;
  logic          rr;          // 0: requester 0 wins a tie, 1: requester 1 wins
  logic          pick1;
  logic          grant;
  logic          bit_end;
  logic [7:0]    sel_byte;

  assign pick1    = req1 && (!req0 || rr);
  assign sel_byte = pick1 ? data1 : data0;
  assign bit_end  = sample_ENABLE && (sample_cnt == LAST_SMP);

  // NOTE: the grant is decoded combinationally so it lands in the same IDLE
  // cycle the request is seen; reset gates it so no grant escapes during reset.
  assign grant = !reset && (state == IDLE) && (req0 || req1);
  assign gnt0  = grant && !pick1;
  assign gnt1  = grant && pick1;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      rr          <= 1'b0;
      baud_select <= RESET_BAUD;
      TxD         <= 1'b1;
      Tx_BUSY     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
          if (req0 || req1) begin
            shift       <= sel_byte;
            parity      <= ^sel_byte;
            baud_select <= cfg_baud_select;
            rr          <= ~pick1;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            state       <= START;
            TxD         <= 1'b0;
            Tx_BUSY     <= 1'b1;
          end
        end
        START, DATA, PARITY, STOP: begin
          if (sample_ENABLE) begin
            sample_cnt <= bit_end ? '0 : sample_cnt + 1'b1;
          end
          if (bit_end) begin
            case (state)
              START: begin
                state <= DATA;
                TxD   <= shift[0];
              end
              DATA: begin
                if (bit_cnt == 3'd7) begin
                  state <= PARITY;
                  TxD   <= parity;
                end else begin
                  shift   <= {1'b0, shift[7:1]};
                  TxD     <= shift[1];
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
              PARITY: begin
                state <= STOP;
                TxD   <= 1'b1;
              end
              default: begin
                state   <= IDLE;
                TxD     <= 1'b1;
                Tx_BUSY <= 1'b0;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level model checked every cycle, plus
// directed scenarios with hand-computed frames, grant order and timing.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_ENABLE = 1'b0;
  logic [2:0] cfg_baud_select = 3'b000;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       gnt0, gnt1, TxD, Tx_BUSY;
  logic [2:0] baud_select;

  uart_tx_scheduler dut (
    .clk(clk), .reset(reset), .sample_ENABLE(sample_ENABLE),
    .cfg_baud_select(cfg_baud_select),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .baud_select(baud_select),
    .TxD(TxD), .Tx_BUSY(Tx_BUSY)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe source: one pulse every 4 clocks, free-running.
  initial begin
    forever begin
      repeat (3) begin @(posedge clk); #1; sample_ENABLE = 1'b0; end
      @(posedge clk); #1; sample_ENABLE = 1'b1;
    end
  end

  // Frame-level model: a frame is an 11-bit vector {stop, parity, data, start}
  // and bit k is on the line during strobes 16k..16k+15 of the frame.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [10:0] m_bits = '1;
  logic [2:0]  m_bsel = 3'b111;
  logic        m_rr = 1'b0;
  logic        started = 1'b0;
  logic        m_pick1;
  logic [7:0]  m_byte;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_cnt = 0; m_bsel = 3'b111; m_rr = 1'b0;
    end else if (!m_busy) begin
      if (req0 || req1) begin
        m_pick1 = req1 && (!req0 || m_rr);
        m_byte  = m_pick1 ? data1 : data0;
        m_bits  = {1'b1, ^m_byte, m_byte, 1'b0};
        m_bsel  = cfg_baud_select;
        m_rr    = !m_pick1;
        m_busy  = 1'b1;
        m_cnt   = 0;
      end
    end else if (sample_ENABLE) begin
      m_cnt++;
      if (m_cnt == 176) m_busy = 1'b0;
    end
    started = 1'b1;
  end

  // Observation logs filled by the compare process.
  int          grant_log[$];
  logic [10:0] frames[$];
  int          busy_q[$];
  int          gap_q[$];
  int          start_q[$];
  logic [10:0] cap;
  logic        prev_busy = 1'b0;
  logic        in_start = 1'b0;
  int          bs = 0, gap = 0, sc = 0;

  always @(negedge clk) begin
    logic e_txd, e_g, e_p1;
    if (started) begin
      e_txd = m_busy ? m_bits[m_cnt / 16] : 1'b1;
      e_g   = !reset && !m_busy && (req0 || req1);
      e_p1  = req1 && (!req0 || m_rr);
      check("TxD", TxD, e_txd);
      check("Tx_BUSY", Tx_BUSY, m_busy);
      check("baud_select", baud_select, m_bsel);
      check("gnt0", gnt0, e_g && !e_p1);
      check("gnt1", gnt1, e_g && e_p1);

      if (gnt0) grant_log.push_back(0);
      if (gnt1) grant_log.push_back(1);
      if (m_busy && sample_ENABLE && (m_cnt % 16) == 7) cap[m_cnt / 16] = TxD;
      if (m_busy && sample_ENABLE && m_cnt == 175) frames.push_back(cap);

      if (Tx_BUSY && !prev_busy) begin
        gap_q.push_back(gap); gap = 0; bs = 0; in_start = 1'b1; sc = 0;
      end
      if (!Tx_BUSY && prev_busy) busy_q.push_back(bs);
      if (Tx_BUSY && sample_ENABLE) bs++;
      if (!Tx_BUSY) gap++;
      if (in_start) begin
        if (TxD) begin
          in_start = 1'b0;
          start_q.push_back(sc);
        end else if (sample_ENABLE) sc++;
      end
      prev_busy = Tx_BUSY;
    end
  end

  task automatic wait_gnt(input int which, input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0 && gnt0) || (which == 1 && gnt1)) seen = 1'b1;
    end
    check({name, " grant"}, seen, 1'b1);
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic wait_frame_end(input string name);
    for (int i = 0; i < 4 && !Tx_BUSY; i++) @(negedge clk);
    for (int i = 0; i < 2000 && Tx_BUSY; i++) @(negedge clk);
    check({name, " frame end"}, Tx_BUSY, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); frames.delete(); busy_q.delete();
    gap_q.delete(); start_q.delete();
  endtask

  initial begin
    int n;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    check("reset TxD", TxD, 1'b1);
    check("reset Tx_BUSY", Tx_BUSY, 1'b0);
    check("reset baud", baud_select, 3'b111);
    check("reset gnt0", gnt0, 1'b0);
    check("reset gnt1", gnt1, 1'b0);

    // Single frame, 0xAA on requester 0
    clear_logs();
    cfg_baud_select = 3'b010; data0 = 8'hAA; req0 = 1'b1;
    wait_gnt(0, "single");
    drop_reqs();
    check("single baud next cycle", baud_select, 3'b010);
    check("single gnt0 one clk", gnt0, 1'b0);
    wait_frame_end("single");
    check("single frame count", frames.size(), 1);
    if (frames.size() > 0) check("single frame bits", frames[0], 11'b10101010100);
    check("single busy count", busy_q.size(), 1);
    if (busy_q.size() > 0) check("single busy strobes", busy_q[0], 176);
    check("single grant count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("single granted req", grant_log[0], 0);

    // Parity: 0x07 on requester 1
    clear_logs();
    data1 = 8'h07; req1 = 1'b1;
    wait_gnt(1, "parity");
    drop_reqs();
    wait_frame_end("parity");
    if (frames.size() > 0) check("parity frame bits", frames[0], 11'b11000001110);
    else check("parity frame present", frames.size(), 1);

    // Round-robin with both requests held
    clear_logs();
    data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 5000 && grant_log.size() < 4; i++) @(posedge clk);
    #1; req0 = 1'b0; req1 = 1'b0;
    wait_frame_end("rr");
    check("rr grant count", grant_log.size(), 4);
    check("rr frame count", frames.size(), 4);
    if (grant_log.size() == 4 && frames.size() == 4 && gap_q.size() == 4) begin
      check("rr grant 0", grant_log[0], 0);
      check("rr grant 1", grant_log[1], 1);
      check("rr grant 2", grant_log[2], 0);
      check("rr grant 3", grant_log[3], 1);
      check("rr frame 0", frames[0], 11'b10000100010);
      check("rr frame 1", frames[1], 11'b10001000100);
      check("rr frame 2", frames[2], 11'b10000100010);
      check("rr frame 3", frames[3], 11'b10001000100);
      for (int i = 1; i < 4; i++) check("rr idle gap", gap_q[i], 1);
    end else check("rr gap count", gap_q.size(), 4);

    // Baud change mid-frame
    clear_logs();
    cfg_baud_select = 3'b010; data0 = 8'h5A; req0 = 1'b1;
    wait_gnt(0, "baud");
    drop_reqs();
    n = 0;
    for (int i = 0; i < 1000 && n < 40; i++) begin
      @(negedge clk);
      if (sample_ENABLE && Tx_BUSY) n++;
    end
    check("baud 40 strobes seen", n, 40);
    @(posedge clk); #1; cfg_baud_select = 3'b111;
    check("baud held mid-frame", baud_select, 3'b010);
    wait_frame_end("baud");
    check("baud held after frame", baud_select, 3'b010);
    data1 = 8'hC3; req1 = 1'b1;
    wait_gnt(1, "baud2");
    drop_reqs();
    check("baud updated at grant", baud_select, 3'b111);
    wait_frame_end("baud2");

    // Reset during DATA bit 3
    clear_logs();
    cfg_baud_select = 3'b010; data0 = 8'h3C; req0 = 1'b1;
    wait_gnt(0, "rst");
    drop_reqs();
    for (int i = 0; i < 2000 && m_cnt < 70; i++) @(negedge clk);
    check("rst reached data bit 3", (m_cnt >= 64 && m_cnt < 80), 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; data1 = 8'h99;
    grant_log.delete();
    @(posedge clk); #1;
    check("rst TxD", TxD, 1'b1);
    check("rst Tx_BUSY", Tx_BUSY, 1'b0);
    check("rst baud", baud_select, 3'b111);
    check("rst no grant", grant_log.size(), 0);
    reset = 1'b0;
    wait_gnt(0, "rst first");
    drop_reqs();
    if (grant_log.size() > 0) check("rst first grant req0", grant_log[0], 0);
    wait_frame_end("rst");

    // Idle strobes ignored
    clear_logs();
    n = 0;
    for (int i = 0; i < 1000 && n < 50; i++) begin
      @(negedge clk);
      if (sample_ENABLE) n++;
    end
    check("idle strobes seen", n, 50);
    check("idle TxD", TxD, 1'b1);
    check("idle no grant", grant_log.size(), 0);
    cfg_baud_select = 3'b101; data1 = 8'h81; req1 = 1'b1;
    wait_gnt(1, "idle");
    drop_reqs();
    wait_frame_end("idle");
    if (start_q.size() > 0) check("idle start bit strobes", start_q[start_q.size() - 1], 16);
    else check("idle start bit seen", start_q.size(), 1);
    if (frames.size() > 0) check("idle frame bits", frames[0], 11'b10100000010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit path between two byte requesters (round-robin) and sequences the serial frame: start, 8 data bits LSB-first, even parity, stop.
- Sits between the requesters and the TxD pin.
- Paces every bit from the 16x oversampling strobe produced by the baud controller.
- Owns the baud controller's baud_select input and changes it only between frames.

Parameters:
- SAMPLES_PER_BIT, 16, sample_ENABLE pulses per serial bit.
- RESET_BAUD, 3'b111, value driven on baud_select out of reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_ENABLE  input  1  one-clk strobe from the baud controller, 16x baud rate.
- cfg_baud_select  input  3  requested baud code; sampled only at grant.
- req0  input  1  requester 0 has a byte; level, held until gnt0.
- data0  input  8  requester 0 byte; valid while req0=1.
- req1  input  1  requester 1 has a byte.
- data1  input  8  requester 1 byte.
- gnt0  output  1  one-clk pulse: data0 captured.
- gnt1  output  1  one-clk pulse: data1 captured.
- baud_select  output  3  registered, to the baud controller.
- TxD  output  1  serial line, idle high.
- Tx_BUSY  output  1  high from the cycle after grant until the stop bit ends.

Behaviour:
- Reset (sync, active-high, dominates everything):
  - TxD=1, Tx_BUSY=0, gnt0=gnt1=0, baud_select=RESET_BAUD.
  - FSM=IDLE, bit counter=0, sample counter=0, rr pointer=0 (requester 0 preferred).
- Reset mid-frame: frame abandoned; TxD=1 on the next edge; no gnt is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TxD=1, Tx_BUSY=0.
  - If either req is high, grant in that same cycle.
  - Only req0 high -> gnt0; only req1 high -> gnt1.
  - Both high -> grant the requester selected by the rr pointer.
  - On grant:
    - capture the byte into shift register;
    - compute parity = XOR of the byte;
    - load baud_select <= cfg_baud_select;
    - flip the rr pointer to the other requester;
    - clear the sample counter;
    - next state START.
  - gnt lasts exactly one cycle.
  - Only one grant per frame; at least one IDLE cycle separates frames.
- START: TxD=0. DATA: TxD=shift[0]. PARITY: TxD=parity. STOP: TxD=1. Tx_BUSY=1 in all four.
- Bit timing:
  - The sample counter increments on each sample_ENABLE while not IDLE.
  - When a pulse arrives with the counter at SAMPLES_PER_BIT-1, the bit ends: counter wraps to 0 and the state advances on that edge.
  - TxD changes the cycle after the 16th pulse.
  - Each bit lasts exactly 16 strobes; one frame = 11 bits = 176 strobes.
- DATA: shift right on each bit end; bit counter 0..7. After bit 7 ends -> PARITY.
- PARITY end -> STOP. STOP end -> IDLE (Tx_BUSY=0 that cycle). A grant in that IDLE cycle is allowed.
- sample_ENABLE pulses in IDLE are ignored.
- The first counted pulse is the first pulse after the grant cycle.
- req deasserted after grant has no effect on the frame in flight.
- data0/data1 changes after capture are ignored.
- cfg_baud_select changes during a frame are ignored until the next grant.
- baud_select never changes while Tx_BUSY=1.
- gnt0 and gnt1 are never high together.

Test Plan:
- Single frame:
  - Reset 2 cycles; cfg_baud_select=3'b010; req0=1, data0=8'hAA.
  - Required: gnt0 pulse 1 clk; baud_select=3'b010 the next cycle.
  - TxD bits (16 strobes each) = 0, 0,1,0,1,0,1,0,1, parity 0, stop 1.
  - Tx_BUSY high for exactly 176 strobes; gnt1 never asserted.
- Parity:
  - data1=8'h07 alone -> gnt1; data bits 1,1,1,0,0,0,0,0; parity bit 1.
- Round-robin:
  - req0=req1=1 held continuously, data0=8'h11, data1=8'h22.
  - Required: grants alternate gnt0, gnt1, gnt0, gnt1 with frames 11,22,11,22; exactly one IDLE cycle between frames.
- Baud change mid-frame:
  - Start a frame with cfg=3'b010; change cfg to 3'b111 after 40 strobes.
  - Required: baud_select stays 3'b010 until the next grant, then 3'b111.
- Reset mid-frame:
  - Assert reset during DATA bit 3.
  - Required: next edge TxD=1, Tx_BUSY=0, baud_select=3'b111.
  - With both reqs high after reset, the first grant goes to req0.
- Idle strobes:
  - 50 sample_ENABLE pulses with no req -> TxD stays 1, no gnt.
  - A subsequent frame's start bit still lasts exactly 16 strobes.
